// File: rtl/lstm_seq_sequencer.sv
// lstm_seq_sequencer: timestep sequencer closing the recurrence loop of lstm_cell.
// Accepts SEQ_LEN samples over valid/ready, presents each to the cell with the
// held h/c state, captures h_t/c_t after CELL_LATENCY edges, and emits the
// final hidden state over a valid/ready output handshake.
// Optional feature macro: LSTM_SEQ_STATE_CARRY_EN -- when defined, h/c state
// is carried into the next sequence instead of being cleared on output handshake.
module lstm_seq_sequencer #(
    parameter int N            = 8,
    parameter int HIDDEN_SIZE  = 64,
    parameter int SEQ_LEN      = 16,
    parameter int CELL_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_data,
    output logic [N-1:0]           cell_x,
    output logic [HIDDEN_SIZE-1:0] cell_h_prev,
    output logic [HIDDEN_SIZE-1:0] cell_c_prev,
    input  logic [HIDDEN_SIZE-1:0] cell_h,
    input  logic [HIDDEN_SIZE-1:0] cell_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [HIDDEN_SIZE-1:0] out_h,
    output logic                   busy
);

    localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int WCNT_W = (CELL_LATENCY > 0) ? $clog2(CELL_LATENCY + 1) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(CELL_LATENCY);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [N-1:0]            x_reg;
    logic [HIDDEN_SIZE-1:0]  h_state, c_state;
    logic [STEP_W-1:0]       step;
    logic [WCNT_W-1:0]       wcnt;
    logic                    accept;
    logic                    capture;

    // Cell inputs and result are straight wires from the held registers.
    assign cell_x      = x_reg;
    assign cell_h_prev = h_state;
    assign cell_c_prev = c_state;
    assign out_h       = h_state;
    assign busy        = (state_q != ST_ACCEPT) || (step != '0);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement or process order.
        if (reset) state_q <= ST_ACCEPT;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs; depend only on state, never on the
    // partner's valid/ready, so no combinational path across a handshake.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt == '0) begin
                    capture = 1'b1;
                    state_d = (step == STEP_LAST) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_ACCEPT;
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // Datapath: sample latch, latency countdown, state capture and step count.
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is reset so the cell sees all-zero
        // inputs right after reset; there is no memory array to leave unreset.
        if (reset) begin
            x_reg   <= '0;
            h_state <= '0;
            c_state <= '0;
            step    <= '0;
            wcnt    <= '0;
        end else begin
            if (accept) begin
                x_reg <= in_data;
                wcnt  <= WCNT_INIT;
            end
            if (state_q == ST_WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            if (capture) begin
                h_state <= cell_h;
                c_state <= cell_c;
                step    <= (step == STEP_LAST) ? '0 : step + 1'b1;
            end
`ifndef LSTM_SEQ_STATE_CARRY_EN
            if (state_q == ST_DONE && out_ready) begin
                h_state <= '0;
                c_state <= '0;
            end
`endif
        end
    end

endmodule
